// File: rtl/gpio_pkg.sv
// GPIO shared definitions: default sizing used by the input and output sides.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package gpio_pkg;

   localparam int GPIO_WIDTH_DEF = 8;   // pins per GPIO block
   localparam int GPIO_DB_W_DEF  = 16;  // debounce counter / db_limit width
   localparam int GPIO_SYNC_DEF  = 2;   // synchroniser depth

   // Edge kinds the input side can latch; software-visible encoding.
   typedef enum logic [1:0] {
      GPIO_EDGE_NONE = 2'b00,
      GPIO_EDGE_RISE = 2'b01,
      GPIO_EDGE_FALL = 2'b10
   } gpio_edge_e;

endpackage : gpio_pkg

// File: rtl/gpio_debounce.sv
// One-pin synchroniser + debounce counter + debounced level flop.
// Latency: level_o follows a pin step SYNC_STAGES-1+max(db_limit_i,1) cycles after capture.
// Backpressure: none; free-running every cycle.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pin_i      raw pad input, asynchronous to clk
//   db_limit_i consecutive stable cycles required before level_o changes (0 acts as 1)
//   level_o    debounced level
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int DEBOUNCE_W  = GPIO_DB_W_DEF,
   parameter int SYNC_STAGES = GPIO_SYNC_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pin_i,
   input  logic [DEBOUNCE_W-1:0] db_limit_i,
   output logic                  level_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [DEBOUNCE_W-1:0]  cnt_q;
   logic [DEBOUNCE_W-1:0]  cnt_d;
   logic                   level_q;
   logic                   level_d;
   logic                   sync_s;
   logic [DEBOUNCE_W-1:0]  limit_eff;
   logic [DEBOUNCE_W:0]    cnt_inc;

   // Pure shift chain: no logic between stages so metastability only has flops to settle through.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
   assign sync_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      limit_eff = (db_limit_i == '0) ? {{(DEBOUNCE_W-1){1'b0}}, 1'b1} : db_limit_i;
      // One extra bit so the increment can never wrap before the compare.
      cnt_inc   = {1'b0, cnt_q} + {{DEBOUNCE_W{1'b0}}, 1'b1};
      cnt_d     = cnt_q;
      level_d   = level_q;
      if (sync_s == level_q) begin
         // Stable or a glitch returned: restart the qualification window.
         cnt_d = '0;
      end else if (cnt_inc >= {1'b0, limit_eff}) begin
         // >= rather than == so a lowered db_limit mid-count commits immediately.
         level_d = sync_s;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_inc[DEBOUNCE_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;

endmodule : gpio_debounce

// File: rtl/gpio_in_irq.sv
// GPIO input side: per-pin sync/debounce, edge detect, W1C pending register, masked irq.
// Latency: pending_o sets 1 cycle after level_o changes; irq_o 1 cycle after pending_o.
// Backpressure: none; edges on an already-pending bit are absorbed.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   gpio_i              raw pad inputs (asynchronous)
//   db_limit            debounce stable-cycle count, 0 behaves as 1
//   rise_en / fall_en   per-pin edge enables into pending
//   irq_mask            per-pin contribution to irq_o
//   clr_valid/clr_bits  one-cycle write-1-to-clear of pending bits
//   level_o             debounced levels
//   pending_o           latched edge events
//   irq_o               registered |(pending_o & irq_mask)
module gpio_in_irq
   import gpio_pkg::*;
#(
   parameter int WIDTH       = GPIO_WIDTH_DEF,
   parameter int DEBOUNCE_W  = GPIO_DB_W_DEF,
   parameter int SYNC_STAGES = GPIO_SYNC_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      gpio_i,
   input  logic [DEBOUNCE_W-1:0] db_limit,
   input  logic [WIDTH-1:0]      rise_en,
   input  logic [WIDTH-1:0]      fall_en,
   input  logic [WIDTH-1:0]      irq_mask,
   input  logic                  clr_valid,
   input  logic [WIDTH-1:0]      clr_bits,
   output logic [WIDTH-1:0]      level_o,
   output logic [WIDTH-1:0]      pending_o,
   output logic                  irq_o
);

   logic [WIDTH-1:0] level_w;
   logic [WIDTH-1:0] lvl_q;
   logic [WIDTH-1:0] pending_q;
   logic [WIDTH-1:0] pending_d;
   logic             irq_q;
   logic             irq_d;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] clr_mask;

   for (genvar p = 0; p < WIDTH; p++) begin : g_pin
      gpio_debounce #(
         .DEBOUNCE_W  (DEBOUNCE_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_db (
         .clk        (clk),
         .rst_n      (rst_n),
         .pin_i      (gpio_i[p]),
         .db_limit_i (db_limit),
         .level_o    (level_w[p])
      );
   end

   always_comb begin
      rise     = level_w & ~lvl_q;
      fall     = ~level_w & lvl_q;
      clr_mask = clr_valid ? clr_bits : '0;
      // Set terms are OR'd after the clear so a same-cycle edge is never lost.
      pending_d = (pending_q & ~clr_mask) | (rise & rise_en) | (fall & fall_en);
      irq_d     = |(pending_q & irq_mask);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q     <= '0;
         pending_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         lvl_q     <= level_w;
         pending_q <= pending_d;
         irq_q     <= irq_d;
      end
   end

   assign level_o   = level_w;
   assign pending_o = pending_q;
   assign irq_o     = irq_q;

endmodule : gpio_in_irq

// File: tb/tb_gpio_in_irq.sv
module tb_gpio_in_irq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  gpio_i = '0;
   logic [15:0] db_limit = 16'd1;
   logic [7:0]  rise_en = '0;
   logic [7:0]  fall_en = '0;
   logic [7:0]  irq_mask = '0;
   logic        clr_valid = 1'b0;
   logic [7:0]  clr_bits = '0;
   logic [7:0]  level_o;
   logic [7:0]  pending_o;
   logic        irq_o;

   int total = 0;
   int bad   = 0;

   gpio_in_irq #(.WIDTH(8), .DEBOUNCE_W(16), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gpio_i    (gpio_i),
      .db_limit  (db_limit),
      .rise_en   (rise_en),
      .fall_en   (fall_en),
      .irq_mask  (irq_mask),
      .clr_valid (clr_valid),
      .clr_bits  (clr_bits),
      .level_o   (level_o),
      .pending_o (pending_o),
      .irq_o     (irq_o)
   );

   always #5 clk = ~clk;

   // Advance n rising edges; leaves time 1 unit after the last edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic init_inputs();
      gpio_i    = '0;
      db_limit  = 16'd1;
      rise_en   = '0;
      fall_en   = '0;
      irq_mask  = '0;
      clr_valid = 1'b0;
      clr_bits  = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      init_inputs();
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      gpio_i   = 8'hFF;
      rise_en  = 8'hFF;
      fall_en  = 8'hFF;
      irq_mask = 8'hFF;
      tick(4);
      total++;
      if (level_o !== 8'h00) begin bad++; $display("FAIL reset_level got=%h exp=00", level_o); end
      total++;
      if (pending_o !== 8'h00) begin bad++; $display("FAIL reset_pending got=%h exp=00", pending_o); end
      total++;
      if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
   endtask

   // Step on pin 0 with db_limit=4: level at edge 5, pending at 6, irq at 7.
   task automatic test_latency();
      do_reset();
      db_limit = 16'd4;
      rise_en  = 8'h01;
      irq_mask = 8'h01;
      gpio_i   = 8'h01;
      for (int e = 0; e <= 7; e++) begin
         tick(1);
         total++;
         if (level_o[0] !== (e >= 5)) begin
            bad++; $display("FAIL lat_level edge=%0d got=%b exp=%b", e, level_o[0], e >= 5);
         end
         total++;
         if (pending_o[0] !== (e >= 6)) begin
            bad++; $display("FAIL lat_pending edge=%0d got=%b exp=%b", e, pending_o[0], e >= 6);
         end
         total++;
         if (irq_o !== (e >= 7)) begin
            bad++; $display("FAIL lat_irq edge=%0d got=%b exp=%b", e, irq_o, e >= 7);
         end
      end
   endtask

   // 3-cycle pulse rejected; a following 4-cycle pulse gets through.
   task automatic test_glitch();
      do_reset();
      db_limit = 16'd4;
      rise_en  = 8'h02;
      irq_mask = 8'h02;
      gpio_i   = 8'h02;
      tick(3);
      gpio_i = 8'h00;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         total++;
         if (level_o[1] !== 1'b0) begin
            bad++; $display("FAIL glitch_level cyc=%0d got=%b exp=0", i, level_o[1]);
         end
         total++;
         if (pending_o !== 8'h00) begin
            bad++; $display("FAIL glitch_pending cyc=%0d got=%h exp=00", i, pending_o);
         end
      end
      gpio_i = 8'h02;
      tick(4);
      gpio_i = 8'h00;
      tick(3);
      total++;
      if (level_o[1] !== 1'b1) begin bad++; $display("FAIL pulse4_level got=%b exp=1", level_o[1]); end
      total++;
      if (pending_o !== 8'h02) begin bad++; $display("FAIL pulse4_pending got=%h exp=02", pending_o); end
   endtask

   // Clear and fall-edge set land on pin 2 in the same cycle: set wins.
   task automatic test_set_wins();
      do_reset();
      db_limit = 16'd1;
      rise_en  = 8'h04;
      fall_en  = 8'h04;
      gpio_i   = 8'h04;
      tick(4);
      total++;
      if (pending_o !== 8'h04) begin bad++; $display("FAIL sw_rise_pending got=%h exp=04", pending_o); end
      gpio_i = 8'h00;
      tick(3);
      total++;
      if (level_o[2] !== 1'b0) begin bad++; $display("FAIL sw_level_fall got=%b exp=0", level_o[2]); end
      clr_valid = 1'b1;
      clr_bits  = 8'h04;
      tick(1);
      clr_valid = 1'b0;
      total++;
      if (pending_o[2] !== 1'b1) begin bad++; $display("FAIL sw_set_wins got=%b exp=1", pending_o[2]); end
      tick(1);
      total++;
      if (pending_o !== 8'h04) begin bad++; $display("FAIL sw_no_valid_no_clear got=%h exp=04", pending_o); end
      clr_valid = 1'b1;
      tick(1);
      clr_valid = 1'b0;
      clr_bits  = 8'h00;
      total++;
      if (pending_o !== 8'h00) begin bad++; $display("FAIL sw_clear got=%h exp=00", pending_o); end
   endtask

   // Pins 3 and 4 pending, only pin 3 unmasked; clearing pin 3 drops irq a cycle later.
   task automatic test_mask_clear();
      do_reset();
      db_limit = 16'd1;
      rise_en  = 8'h18;
      irq_mask = 8'h08;
      gpio_i   = 8'h18;
      tick(5);
      total++;
      if (pending_o !== 8'h18) begin bad++; $display("FAIL mc_pending got=%h exp=18", pending_o); end
      total++;
      if (irq_o !== 1'b1) begin bad++; $display("FAIL mc_irq_set got=%b exp=1", irq_o); end
      clr_valid = 1'b1;
      clr_bits  = 8'h08;
      tick(1);
      clr_valid = 1'b0;
      clr_bits  = 8'h00;
      total++;
      if (pending_o !== 8'h10) begin bad++; $display("FAIL mc_pending_after_clr got=%h exp=10", pending_o); end
      total++;
      if (irq_o !== 1'b1) begin bad++; $display("FAIL mc_irq_lag got=%b exp=1", irq_o); end
      tick(1);
      total++;
      if (irq_o !== 1'b0) begin bad++; $display("FAIL mc_irq_drop got=%b exp=0", irq_o); end
      total++;
      if (pending_o !== 8'h10) begin bad++; $display("FAIL mc_pending_hold got=%h exp=10", pending_o); end
      irq_mask = 8'h10;
      tick(1);
      total++;
      if (irq_o !== 1'b1) begin bad++; $display("FAIL mc_mask_change got=%b exp=1", irq_o); end
   endtask

   // db_limit=0 on pin 5 toggling every 2 cycles; clearing every cycle exposes each edge.
   task automatic test_fast_toggle();
      logic g [40];
      logic lk, lk1, lk2;
      int   seen;
      int   want;
      do_reset();
      db_limit  = 16'd0;
      rise_en   = 8'h20;
      fall_en   = 8'h20;
      clr_valid = 1'b1;
      clr_bits  = 8'h20;
      seen      = 0;
      want      = 0;
      for (int k = 0; k < 40; k++) g[k] = ((k / 2) % 2) == 1;
      for (int j = 1; j <= 36; j++) if (g[j] != g[j-1]) want++;
      for (int k = 0; k < 40; k++) begin
         gpio_i[5] = g[k];
         tick(1);
         lk  = (k >= 2) ? g[k-2] : 1'b0;
         lk1 = (k >= 3) ? g[k-3] : 1'b0;
         lk2 = (k >= 4) ? g[k-4] : 1'b0;
         total++;
         if (level_o[5] !== lk) begin
            bad++; $display("FAIL ft_level k=%0d got=%b exp=%b", k, level_o[5], lk);
         end
         total++;
         if (pending_o[5] !== (lk1 ^ lk2)) begin
            bad++; $display("FAIL ft_pending k=%0d got=%b exp=%b", k, pending_o[5], lk1 ^ lk2);
         end
         if (pending_o[5] === 1'b1) seen++;
      end
      clr_valid = 1'b0;
      clr_bits  = 8'h00;
      total++;
      if (seen !== want) begin bad++; $display("FAIL ft_edge_count got=%0d exp=%0d", seen, want); end
   endtask

   // Asynchronous reset mid-count; afterwards the pins need the full 1000 cycles again.
   task automatic test_reset_mid();
      do_reset();
      db_limit = 16'd1;
      rise_en  = 8'hC0;
      irq_mask = 8'h80;
      gpio_i   = 8'h80;
      tick(5);
      total++;
      if ({level_o, pending_o, irq_o} !== {8'h80, 8'h80, 1'b1}) begin
         bad++; $display("FAIL rm_pre got=%h/%h/%b exp=80/80/1", level_o, pending_o, irq_o);
      end
      db_limit = 16'd1000;
      gpio_i   = 8'hC0;
      tick(500);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({level_o, pending_o, irq_o} !== 17'd0) begin
         bad++; $display("FAIL rm_async got=%h/%h/%b exp=00/00/0", level_o, pending_o, irq_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(1001);
      total++;
      if (level_o !== 8'h00) begin bad++; $display("FAIL rm_level_early got=%h exp=00", level_o); end
      tick(1);
      total++;
      if (level_o !== 8'hC0) begin bad++; $display("FAIL rm_level got=%h exp=C0", level_o); end
      tick(1);
      total++;
      if (pending_o !== 8'hC0) begin bad++; $display("FAIL rm_pending got=%h exp=C0", pending_o); end
      tick(1);
      total++;
      if (irq_o !== 1'b1) begin bad++; $display("FAIL rm_irq got=%b exp=1", irq_o); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_glitch();
      test_set_wins();
      test_mask_clear();
      test_fast_toggle();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_gpio_in_irq
